// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter: serves iCache/dCache line fills and dCache
// write-backs, one memory transaction at a time, with round-robin read fairness.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 128
`endif

module mem_arbiter #(
    parameter int WORD_SIZE = `WORD_SIZE,
    parameter int LINE_SIZE = `CACHE_LINE_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_req_addr,
    output logic                 i_res,
    output logic [WORD_SIZE-1:0] i_res_addr,
    output logic [LINE_SIZE-1:0] i_res_data,

    input  logic                 d_req,
    input  logic [WORD_SIZE-1:0] d_req_addr,
    output logic                 d_res,
    output logic [WORD_SIZE-1:0] d_res_addr,
    output logic [LINE_SIZE-1:0] d_res_data,

    input  logic                 d_write,
    input  logic [WORD_SIZE-1:0] d_write_addr,
    input  logic [LINE_SIZE-1:0] d_write_data,
    output logic                 d_write_done,

    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_req_addr,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_write_addr,
    output logic [LINE_SIZE-1:0] mem_write_data,
    input  logic                 mem_res,
    input  logic [WORD_SIZE-1:0] mem_res_addr,
    input  logic [LINE_SIZE-1:0] mem_res_data
);

    typedef enum logic [2:0] {IDLE, ISSUE, BUSY_I, BUSY_DR, BUSY_DW} state_t;
    typedef enum logic [1:0] {OWN_I, OWN_DR, OWN_DW} owner_t;

    state_t                 state, state_nxt;
    owner_t                 owner_q, gnt_owner;
    logic                   gnt_valid;
    logic [WORD_SIZE-1:0]   gnt_addr;
    logic [WORD_SIZE-1:0]   addr_q;
    logic [LINE_SIZE-1:0]   wdata_q;
    logic                   rr_q;
    logic                   hit;

    // A completion must match the outstanding address; reset masks any late pulse.
    assign hit = mem_res && (mem_res_addr == addr_q) && !rst;

    // Write-back wins; otherwise rr picks between simultaneous reads.
    always_comb begin
        // NOTE: every variable gets a default before the branches so no latch is inferred.
        gnt_valid = 1'b0;
        gnt_owner = OWN_I;
        gnt_addr  = '0;
        if (d_write) begin
            gnt_valid = 1'b1;
            gnt_owner = OWN_DW;
            gnt_addr  = d_write_addr;
        end else if (i_req && d_req) begin
            gnt_valid = 1'b1;
            gnt_owner = rr_q ? OWN_DR : OWN_I;
            gnt_addr  = rr_q ? d_req_addr : i_req_addr;
        end else if (i_req) begin
            gnt_valid = 1'b1;
            gnt_owner = OWN_I;
            gnt_addr  = i_req_addr;
        end else if (d_req) begin
            gnt_valid = 1'b1;
            gnt_owner = OWN_DR;
            gnt_addr  = d_req_addr;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = ISSUE;
            ISSUE: begin
                case (owner_q)
                    OWN_DR:  state_nxt = BUSY_DR;
                    OWN_DW:  state_nxt = BUSY_DW;
                    default: state_nxt = BUSY_I;
                endcase
            end
            BUSY_I, BUSY_DR, BUSY_DW: if (hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_I;
            addr_q  <= '0;
            wdata_q <= '0;
            rr_q    <= 1'b0;
        end else begin
            if (state == IDLE && gnt_valid) begin
                owner_q <= gnt_owner;
                addr_q  <= gnt_addr;
                wdata_q <= (gnt_owner == OWN_DW) ? d_write_data : '0;
            end
            // Write-backs leave the read fairness pointer alone.
            if (hit && state == BUSY_I)  rr_q <= 1'b1;
            if (hit && state == BUSY_DR) rr_q <= 1'b0;
        end
    end

    assign mem_req_addr   = addr_q;
    assign mem_write_addr = addr_q;
    assign mem_write_data = wdata_q;

    always_comb begin
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        i_res        = 1'b0;
        i_res_addr   = '0;
        i_res_data   = '0;
        d_res        = 1'b0;
        d_res_addr   = '0;
        d_res_data   = '0;
        d_write_done = 1'b0;
        case (state)
            ISSUE: begin
                mem_req   = (owner_q != OWN_DW);
                mem_write = (owner_q == OWN_DW);
            end
            BUSY_I: if (hit) begin
                i_res      = 1'b1;
                i_res_addr = mem_res_addr;
                i_res_data = mem_res_data;
            end
            BUSY_DR: if (hit) begin
                d_res      = 1'b1;
                d_res_addr = mem_res_addr;
                d_res_data = mem_res_data;
            end
            BUSY_DW: if (hit) d_write_done = 1'b1;
            default: ;
        endcase
    end

endmodule
